button_conditioner: RTL and testbench

Parametrised N-channel input conditioner replacing the per-signal two-flop synchronisers and single-channel confirm one-shot FSM in the top level. Every raw pushbutton or switch pin passes through a configurable synchroniser and a per-channel debounce FSM. Each channel produces:
- a clean level,
- a one-cycle press pulse,
- a one-cycle release pulse.

It sits between the chip input pins and the game logic (ownership, PvE, PvP select, new game, debug select). An optional auto-repeat mode serves held column-select buttons.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/button_channel.sv | 135 +++++++++++++
 rtl/button_conditioner.sv | 44 ++++
 tb/tb_button_conditioner.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioner.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        QUIET   = 3'd4
    } btn_state_t;

    localparam int unsigned FPGA_DEBOUNCE_LIMIT = 6_250_000;
    localparam int unsigned SIM_DEBOUNCE_LIMIT  = 0;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One input channel: synchroniser, debounce FSM and lockout counter.
// Auto-repeat of press_pulse while held is built only when BTN_AUTOREPEAT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a synchronised high input
// PRESS   | one-cycle press strobe, lockout counter cleared
// HOLD    | button down; release accepted only after the lockout expires
// RELEASE | one-cycle release strobe, lockout counter cleared
// QUIET   | input ignored until the lockout expires
module button_channel
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_LIMIT = FPGA_DEBOUNCE_LIMIT,
    parameter int unsigned CNT_W          = width_for(DEBOUNCE_LIMIT),
    parameter int unsigned REPEAT_DELAY   = 25_000_000,
    parameter int unsigned REPEAT_PERIOD  = 5_000_000
)(
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    if (SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_channel: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_LIMIT);

    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_bit;
    logic                   cnt_done;
    logic                   rpt_pulse;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign cnt_done = (cnt_q >= LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync_bit) state_d = PRESS;
            end
            PRESS: begin
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (!cnt_done) cnt_d = cnt_q + 1'b1;
                if (!sync_bit && cnt_done) state_d = RELEASE;
            end
            RELEASE: begin
                cnt_d   = '0;
                state_d = QUIET;
            end
            QUIET: begin
                if (cnt_done) state_d = IDLE;
                else          cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = width_for(RPT_MAX);

    // rpt_q counts down to the next repeat; the strobe is registered so it
    // is decided one cycle ahead, when rpt_q reaches 1.
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_pulse_q, rpt_pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q       <= '0;
            rpt_pulse_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_pulse_q <= rpt_pulse_d;
        end
    end

    always_comb begin
        rpt_d       = rpt_q;
        rpt_pulse_d = 1'b0;
        if (state_q == PRESS) begin
            if (REPEAT_DELAY == 1) begin
                rpt_pulse_d = sync_bit;
                rpt_d       = RPT_W'(REPEAT_PERIOD);
            end else begin
                rpt_d       = RPT_W'(REPEAT_DELAY - 1);
            end
        end else if (state_q == HOLD) begin
            if (rpt_q == RPT_W'(1)) begin
                rpt_pulse_d = sync_bit;
                rpt_d       = RPT_W'(REPEAT_PERIOD);
            end else begin
                rpt_d       = rpt_q - 1'b1;
            end
        end
    end

    assign rpt_pulse = rpt_pulse_q;
`else
    assign rpt_pulse = 1'b0;
`endif

    always_comb begin
        level         = (state_q == PRESS) || (state_q == HOLD);
        press_pulse   = (state_q == PRESS) || rpt_pulse;
        release_pulse = (state_q == RELEASE);
        busy          = (state_q != IDLE);
    end

endmodule

// File: rtl/button_conditioner.sv
// N-channel pushbutton/switch conditioner: one independent button_channel per pin.
// Define BTN_AUTOREPEAT_EN to build press_pulse auto-repeat on held buttons.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_CH           = 12,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_LIMIT = FPGA_DEBOUNCE_LIMIT,
    parameter int unsigned CNT_W          = width_for(DEBOUNCE_LIMIT),
    parameter int unsigned REPEAT_DELAY   = 25_000_000,
    parameter int unsigned REPEAT_PERIOD  = 5_000_000
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            busy
);

    logic [N_CH-1:0] busy_ch;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .CNT_W          (CNT_W),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw_in        (raw_in[i]),
            .level         (level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .busy          (busy_ch[i])
        );
    end

    assign busy = |busy_ch;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (lockout 4 and lockout 0) against a timestamp model.
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int LA = 4;
    localparam int LB = int'(btn_pkg::SIM_DEBOUNCE_LIMIT);
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] raw_a = '0;
    logic [N-1:0] raw_b = '0;
    logic [N-1:0] level_a, press_a, rel_a, level_b, press_b, rel_b;
    logic         busy_a, busy_b;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_LIMIT(LA),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_a), .level(level_a),
        .press_pulse(press_a), .release_pulse(rel_a), .busy(busy_a)
    );

    button_conditioner #(
        .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_LIMIT(LB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_b), .level(level_b),
        .press_pulse(press_b), .release_pulse(rel_b), .busy(busy_b)
    );

    // Reference model: per channel, a raw-sample delay line plus the times of
    // the last accepted press and release; everything else is derived from them.
    bit   hist    [2][N][S];
    int   press_t [2][N];
    int   rel_t   [2][N];
    bit   holding [2][N];
    int   cyc = 0;
    logic [N-1:0] m_level [2];
    logic [N-1:0] m_press [2];
    logic [N-1:0] m_rel   [2];
    logic         m_busy  [2];
    int   m_lim, m_d;
    bit   m_s, m_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < N; c++) begin
                    for (int k = 0; k < S; k++) hist[i][c][k] = 1'b0;
                    press_t[i][c] = -100;
                    rel_t[i][c]   = -100;
                    holding[i][c] = 1'b0;
                end
                m_level[i] = '0; m_press[i] = '0; m_rel[i] = '0; m_busy[i] = 1'b0;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                m_lim = (i == 0) ? LA : LB;
                m_busy[i] = 1'b0;
                for (int c = 0; c < N; c++) begin
                    m_s = hist[i][c][S-1];
                    m_r = (i == 0) ? raw_a[c] : raw_b[c];
                    m_press[i][c] = 1'b0;
                    m_rel[i][c]   = 1'b0;
                    if (!holding[i][c] && (cyc - 1 >= rel_t[i][c] + m_lim + 2) && m_s) begin
                        press_t[i][c] = cyc;
                        holding[i][c] = 1'b1;
                        m_press[i][c] = 1'b1;
                    end else if (holding[i][c] && (cyc - 1 >= press_t[i][c] + 1 + m_lim) && !m_s) begin
                        rel_t[i][c]   = cyc;
                        holding[i][c] = 1'b0;
                        m_rel[i][c]   = 1'b1;
                    end else if (AR && holding[i][c] && m_s) begin
                        m_d = cyc - press_t[i][c];
                        if (m_d == RD || (m_d > RD && (m_d - RD) % RP == 0)) m_press[i][c] = 1'b1;
                    end
                    for (int k = S - 1; k > 0; k--) hist[i][c][k] = hist[i][c][k-1];
                    hist[i][c][0] = m_r;
                    m_level[i][c] = holding[i][c];
                    if (holding[i][c] || cyc < rel_t[i][c] + m_lim + 2) m_busy[i] = 1'b1;
                end
            end
        end
    end

    logic [25:0] dut_vec, exp_vec;
    assign dut_vec = {level_a, press_a, rel_a, busy_a, level_b, press_b, rel_b, busy_b};
    assign exp_vec = {m_level[0], m_press[0], m_rel[0], m_busy[0],
                      m_level[1], m_press[1], m_rel[1], m_busy[1]};

    int checks = 0;
    int passed = 0;

    task automatic test_reset();
        int nfull = 0;
        int at_idx = -1;
        rst_n = 1'b0;
        raw_a = 4'hF;
        raw_b = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== 26'd0) $display("FAIL reset_state got=%h exp=%h", dut_vec, 26'd0);
        else passed++;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
            if (press_a === 4'hF) begin
                nfull++;
                at_idx = i;
            end
        end
        checks++;
        if (nfull !== 1 || at_idx !== 2)
            $display("FAIL reset_first_press count=%0d at=%0d exp count=1 at=2", nfull, at_idx);
        else passed++;
        raw_a = 4'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL reset_drain cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
        end
    endtask

    task automatic test_long_press();
        int np = 0, nr = 0, rel_i = -1, idle_i = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL long_press cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
            if (press_a[0] === 1'b1) np++;
            if (rel_a[0] === 1'b1) begin nr++; rel_i = i; end
            if (rel_i >= 0 && idle_i < 0 && busy_a === 1'b0) idle_i = i;
            raw_a[0] = (i < 20);
        end
        checks++;
        if (np !== 1 || nr !== 1 || idle_i - rel_i !== LA + 2)
            $display("FAIL long_press_counts press=%0d rel=%0d busy_gap=%0d exp 1 1 %0d", np, nr, idle_i - rel_i, LA + 2);
        else passed++;
    endtask

    task automatic test_bounce();
        int np = 0, nr = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
            if (press_a[1] === 1'b1) np++;
            if (rel_a[1] === 1'b1) nr++;
            raw_a[1] = (i < 2) || (i == 3) || (i >= 5 && i < 16) || (i == 18) || (i == 19);
        end
        checks++;
        if (np !== 1 || nr !== 1) $display("FAIL bounce_counts press=%0d rel=%0d exp 1 1", np, nr);
        else passed++;
    endtask

    task automatic test_toggle();
        int np = 0, nr = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL toggle cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
            if (press_b[2] === 1'b1) np++;
            if (rel_b[2] === 1'b1) nr++;
            raw_b[2] = (i < 48) && ((i / 4) % 2 == 0);
        end
        checks++;
        if (np !== 6 || nr !== 6) $display("FAIL toggle_counts press=%0d rel=%0d exp 6 6", np, nr);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int np = 0;
        raw_a[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL mid_hold cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (level_a[3] !== 1'b0 || dut_vec !== 26'd0)
            $display("FAIL mid_reset_async level3=%b vec=%h exp 0 0", level_a[3], dut_vec);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL mid_after cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
            if (press_a[3] === 1'b1) np++;
        end
        checks++;
        if (np !== 1) $display("FAIL mid_repress press=%0d exp 1", np);
        else passed++;
        raw_a[3] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL mid_drain cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
        end
    endtask

    task automatic test_autorepeat();
        int offs[$];
        int first = -1;
        int want[5] = '{0, 10, 13, 16, 19};
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL autorepeat cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
            if (press_a[0] === 1'b1) begin
                if (first < 0) first = i;
                offs.push_back(i - first);
            end
            raw_a[0] = (i < 20);
        end
        checks++;
        if (offs.size() !== 5) $display("FAIL autorepeat_count got=%0d exp=5", offs.size());
        else begin
            passed++;
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (offs[k] !== want[k]) $display("FAIL autorepeat_offset idx=%0d got=%0d exp=%0d", k, offs[k], want[k]);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(5, 0) == 0) raw_a[c] = ~raw_a[c];
                if ($urandom_range(3, 0) == 0) raw_b[c] = ~raw_b[c];
            end
        end
        raw_a = '0;
        raw_b = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            else passed++;
        end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL final_idle busy_a=%b busy_b=%b exp 0 0", busy_a, busy_b);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_long_press();
        test_bounce();
        test_toggle();
        test_reset_mid();
        if (AR) test_autorepeat();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
